// File: rtl/cache_pkg.sv
// Shared definitions for the cache request controller slice.
// Holds default bus widths, the controller state encoding and the
// saturating increment used by the hit/miss statistic counters.
package cache_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MISS_REQ = 3'd2,
    FILL     = 3'd3,
    RESP     = 3'd4
  } state_t;

  // Increment that sticks at the all-ones value of a 'width'-bit counter.
  // Works on a wide carrier so one function serves any counter width;
  // callers cast the result back down to their own width.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= max_val) ? max_val : (val + 64'd1);
  endfunction

endpackage

// File: rtl/cache_req_ctrl_if.sv
// Bus bundle between the cache request controller and its environment.
// Carries the two requester channels, the cache lookup/fill port and the
// backing-memory req/ack port.
//   master : controller side (drives lookup, fill, mem_req, responses)
//   slave  : environment side (requesters, cache array, backing memory)
interface cache_req_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  // requester channels
  logic [1:0]          req;
  logic [2*ADDR_W-1:0] req_addr;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_data;
  // cache port
  logic [ADDR_W-1:0]   cache_addr;
  logic                cache_lookup;
  logic                cache_hit;
  logic [DATA_W-1:0]   cache_rdata;
  logic                cache_victim;
  logic                cache_fill_en;
  logic                cache_fill_way;
  logic [DATA_W-1:0]   cache_fill_data;
  // backing memory port
  logic                mem_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;

  modport master (
    input  req, req_addr, cache_hit, cache_rdata, cache_victim, mem_ack, mem_rdata,
    output rsp_valid, rsp_data, cache_addr, cache_lookup, cache_fill_en,
           cache_fill_way, cache_fill_data, mem_req, mem_addr
  );

  modport slave (
    output req, req_addr, cache_hit, cache_rdata, cache_victim, mem_ack, mem_rdata,
    input  rsp_valid, rsp_data, cache_addr, cache_lookup, cache_fill_en,
           cache_fill_way, cache_fill_data, mem_req, mem_addr
  );
endinterface

// File: rtl/cache_req_ctrl_rr_arb2.sv
// Two-input round-robin arbiter.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   req[1:0]    : request vector
//   advance     : commit the current grant (updates last-grant history)
//   gnt_onehot  : combinational one-hot grant, zero when no request
// After reset requester 0 wins the first contested round.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt_onehot
);

  logic last_grant_reg;

  always_comb begin
    gnt_onehot = 2'b00;
    case (req)
      2'b01:   gnt_onehot = 2'b01;
      2'b10:   gnt_onehot = 2'b10;
      // contested: the requester that did not win last time goes first
      2'b11:   gnt_onehot = last_grant_reg ? 2'b01 : 2'b10;
      default: gnt_onehot = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
    end else if (advance && (|req)) begin
      last_grant_reg <= gnt_onehot[1];
    end
  end

endmodule

// File: rtl/cache_req_ctrl.sv
// Front-end controller for the 2-way set-associative cache.
// Arbitrates two requesters onto the single lookup port, sequences miss
// refills from backing memory and writes them into the victim way, returns
// read data to the granted requester and counts hits/misses (saturating).
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   bus (master)       : requester, cache and memory signals
//   hit_cnt, miss_cnt  : saturating statistic counters
module cache_req_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_req_ctrl_if.master     bus,
  output logic [CNT_W-1:0]     hit_cnt,
  output logic [CNT_W-1:0]     miss_cnt
);

  state_t              state_reg;
  logic                gnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                victim_reg;
  logic [DATA_W-1:0]   data_reg;
  logic                mem_req_reg;
  logic                fill_en_reg;
  logic [1:0]          rsp_valid_reg;
  logic [CNT_W-1:0]    hit_cnt_reg;
  logic [CNT_W-1:0]    miss_cnt_reg;

  logic [1:0]          gnt_onehot;
  logic                gnt_idx;
  logic                arb_advance;
  logic [ADDR_W-1:0]   req_addr_arr [2];
  logic [ADDR_W-1:0]   sel_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_addr_split
      assign req_addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // A grant is taken only from IDLE and never while reset is held, so the
  // lookup strobe stays low during reset.
  assign arb_advance = (state_reg == IDLE) && (|bus.req) && !rst;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (bus.req),
    .advance    (arb_advance),
    .gnt_onehot (gnt_onehot)
  );

  // The grant is one-hot, so bit 1 alone names the winner; bit 0 is folded
  // in so an illegal 2'b11 can never select requester 1.
  assign gnt_idx  = gnt_onehot[1] & ~gnt_onehot[0];
  assign sel_addr = req_addr_arr[gnt_idx];

  // The lookup is issued in the grant cycle itself so the cache answers in
  // LOOKUP; the fill reuses the same address lines from the latched copy.
  assign bus.cache_lookup    = arb_advance;
  assign bus.cache_addr      = arb_advance ? sel_addr : addr_reg;
  assign bus.cache_fill_en   = fill_en_reg;
  assign bus.cache_fill_way  = victim_reg;
  assign bus.cache_fill_data = data_reg;
  assign bus.mem_req         = mem_req_reg;
  assign bus.mem_addr        = addr_reg;
  assign bus.rsp_valid       = rsp_valid_reg;
  assign bus.rsp_data        = data_reg;
  assign hit_cnt             = hit_cnt_reg;
  assign miss_cnt            = miss_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      gnt_reg       <= 1'b0;
      addr_reg      <= '0;
      victim_reg    <= 1'b0;
      data_reg      <= '0;
      mem_req_reg   <= 1'b0;
      fill_en_reg   <= 1'b0;
      rsp_valid_reg <= 2'b00;
      hit_cnt_reg   <= '0;
      miss_cnt_reg  <= '0;
    end else begin
      // single-cycle strobes default low
      fill_en_reg   <= 1'b0;
      rsp_valid_reg <= 2'b00;
      case (state_reg)
        IDLE: begin
          if (arb_advance) begin
            gnt_reg   <= gnt_idx;
            addr_reg  <= sel_addr;
            state_reg <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (bus.cache_hit) begin
            data_reg      <= bus.cache_rdata;
            hit_cnt_reg   <= CNT_W'(sat_inc(64'(hit_cnt_reg), CNT_W));
            rsp_valid_reg <= gnt_reg ? 2'b10 : 2'b01;
            state_reg     <= RESP;
          end else begin
            victim_reg    <= bus.cache_victim;
            miss_cnt_reg  <= CNT_W'(sat_inc(64'(miss_cnt_reg), CNT_W));
            mem_req_reg   <= 1'b1;
            state_reg     <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          // an ack in the very first mem_req cycle is accepted here too
          if (bus.mem_ack) begin
            data_reg    <= bus.mem_rdata;
            mem_req_reg <= 1'b0;
            fill_en_reg <= 1'b1;
            state_reg   <= FILL;
          end
        end
        FILL: begin
          rsp_valid_reg <= gnt_reg ? 2'b10 : 2'b01;
          state_reg     <= RESP;
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // The granted requester must keep req high until it has been answered.
  a_req_held: assert property (@(posedge clk) disable iff (rst)
    (state_reg inside {LOOKUP, MISS_REQ, FILL}) |-> bus.req[gnt_reg]);

  a_rsp_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(rsp_valid_reg));

  a_lookup_fill_excl: assert property (@(posedge clk) disable iff (rst)
    !(bus.cache_lookup && bus.cache_fill_en));

endmodule

// File: tb/tb_cache_req_ctrl.sv
module tb_cache_req_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  cache_req_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  cache_req_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.master),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]        rsp;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                lat;
  } sb_t;
  typedef struct {
    logic              way;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } fill_t;

  sb_t   sb_q[$];
  fill_t fill_q[$];
  sb_t   mon_e;
  fill_t mon_f;

  // environment models
  logic              hit_mode = 1'b1;
  logic              victim_cfg = 1'b0;
  logic [DATA_W-1:0] hit_data [256];
  logic              mem_allowed = 1'b0;
  logic [ADDR_W-1:0] exp_mem_addr = '0;
  int                ack_delay = 1;
  int                mem_cycles = 0;
  logic              late_ack_req = 1'b0;
  logic              auto_ack = 1'b0;

  int   grant_cyc = 0;
  int   last_rsp_cyc = 0;
  logic spacing_on = 1'b0;
  logic have_prev = 1'b0;
  int   exp_hit = 0;
  int   exp_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic push_sb(input logic [1:0] rsp, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data, input int lat);
    sb_t e;
    e.rsp = rsp; e.addr = addr; e.data = data; e.lat = lat;
    sb_q.push_back(e);
  endtask

  task automatic push_fill(input logic way, input logic [DATA_W-1:0] data,
                           input logic [ADDR_W-1:0] addr);
    fill_t f;
    f.way = way; f.data = data; f.addr = addr;
    fill_q.push_back(f);
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int seen = 0;
    int k = 0;
    while (seen < n && k < budget) begin
      @(negedge clk);
      k++;
      if (bus.rsp_valid != 2'b00) seen++;
    end
    check_eq("rsp_count", seen, n);
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    @(negedge clk);
    check_eq({tag, "_hit_cnt"}, hit_cnt, exp_hit);
    check_eq({tag, "_miss_cnt"}, miss_cnt, exp_miss);
  endtask

  // cache array model: answers in the cycle after the lookup strobe
  always @(negedge clk) begin
    if (bus.cache_lookup) begin
      bus.cache_hit    = hit_mode;
      bus.cache_rdata  = hit_data[bus.cache_addr];
      bus.cache_victim = victim_cfg;
    end
  end

  // backing memory model: ack on the ack_delay-th cycle of mem_req
  always @(negedge clk) begin
    if (!mem_allowed) check_eq("no_mem_req", bus.mem_req, 1'b0);
    if (bus.mem_req) begin
      mem_cycles++;
      if (mem_allowed) check_eq("mem_addr", bus.mem_addr, exp_mem_addr);
      auto_ack = (mem_cycles == ack_delay);
    end else begin
      auto_ack = 1'b0;
    end
    bus.mem_ack = auto_ack | late_ack_req;
  end

  // output monitor / scoreboard
  always @(negedge clk) begin
    if (bus.cache_lookup) begin
      grant_cyc = cyc;
      if (sb_q.size() == 0) check_eq("lookup_unexp", bus.cache_lookup, 1'b0);
      else                  check_eq("lookup_addr", bus.cache_addr, sb_q[0].addr);
    end
    if (bus.cache_fill_en) begin
      if (fill_q.size() == 0) begin
        check_eq("fill_unexp", bus.cache_fill_en, 1'b0);
      end else begin
        mon_f = fill_q.pop_front();
        check_eq("fill_way", bus.cache_fill_way, mon_f.way);
        check_eq("fill_data", bus.cache_fill_data, mon_f.data);
        check_eq("fill_addr", bus.cache_addr, mon_f.addr);
      end
    end
    if (bus.rsp_valid != 2'b00) begin
      if (sb_q.size() == 0) begin
        check_eq("rsp_unexp", bus.rsp_valid, 2'b00);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("rsp_valid", bus.rsp_valid, mon_e.rsp);
        check_eq("rsp_data", bus.rsp_data, mon_e.data);
        check_eq("rsp_latency", cyc - grant_cyc, mon_e.lat);
        if (spacing_on && have_prev) check_eq("rsp_spacing", cyc - last_rsp_cyc, 3);
        $display("RSP cyc=%0d valid=%b data=%h lat=%0d", cyc, bus.rsp_valid, bus.rsp_data,
                 cyc - grant_cyc);
      end
      last_rsp_cyc = cyc;
      have_prev = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) hit_data[i] = 8'h00;
    hit_data[22] = 8'hA5;
    hit_data[26] = 8'h61;
    hit_data[29] = 8'h92;
    bus.req       = 2'b00;
    bus.req_addr  = '0;
    bus.mem_rdata = '0;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_rsp_valid", bus.rsp_valid, 2'b00);
    check_eq("rst_mem_req", bus.mem_req, 1'b0);
    check_eq("rst_fill_en", bus.cache_fill_en, 1'b0);
    check_eq("rst_lookup", bus.cache_lookup, 1'b0);
    check_eq("rst_hit_cnt", hit_cnt, 0);
    check_eq("rst_miss_cnt", miss_cnt, 0);
    next_drive();
    rst = 1'b0;
    next_drive();

    // single hit, requester 0
    hit_mode = 1'b1;
    bus.req_addr = {8'd0, 8'd22};
    push_sb(2'b01, 8'd22, 8'hA5, 2);
    bus.req = 2'b01;
    exp_hit = sat(exp_hit);
    wait_rsp(1, 20);
    next_drive();
    bus.req = 2'b00;
    check_counters("hit1");

    // miss with 3-cycle memory latency, requester 1, victim way 1
    next_drive();
    hit_mode = 1'b0; victim_cfg = 1'b1;
    bus.mem_rdata = 8'h3C; ack_delay = 3; mem_cycles = 0;
    exp_mem_addr = 8'd24; mem_allowed = 1'b1;
    bus.req_addr = {8'd24, 8'd0};
    push_sb(2'b10, 8'd24, 8'h3C, 6);
    push_fill(1'b1, 8'h3C, 8'd24);
    bus.req = 2'b10;
    exp_miss = sat(exp_miss);
    wait_rsp(1, 40);
    next_drive();
    bus.req = 2'b00; mem_allowed = 1'b0;
    check_eq("miss_mem_cycles", mem_cycles, 3);
    check_counters("miss1");

    // contested hits: grants alternate 0,1,0,1
    next_drive();
    hit_mode = 1'b1;
    bus.req_addr = {8'd29, 8'd26};
    for (int i = 0; i < 2; i++) begin
      push_sb(2'b01, 8'd26, 8'h61, 2);
      push_sb(2'b10, 8'd29, 8'h92, 2);
      exp_hit = sat(sat(exp_hit));
    end
    have_prev = 1'b0; spacing_on = 1'b1;
    bus.req = 2'b11;
    wait_rsp(4, 40);
    next_drive();
    bus.req = 2'b00; spacing_on = 1'b0;
    check_counters("rr");

    // miss acknowledged in the first mem_req cycle
    next_drive();
    hit_mode = 1'b0; victim_cfg = 1'b0;
    bus.mem_rdata = 8'h77; ack_delay = 1; mem_cycles = 0;
    exp_mem_addr = 8'd40; mem_allowed = 1'b1;
    bus.req_addr = {8'd0, 8'd40};
    push_sb(2'b01, 8'd40, 8'h77, 4);
    push_fill(1'b0, 8'h77, 8'd40);
    bus.req = 2'b01;
    exp_miss = sat(exp_miss);
    wait_rsp(1, 20);
    next_drive();
    bus.req = 2'b00; mem_allowed = 1'b0;
    check_eq("fast_mem_cycles", mem_cycles, 1);
    check_counters("fast");

    // reset during MISS_REQ, then a late ack
    next_drive();
    hit_mode = 1'b0; ack_delay = 1000; mem_cycles = 0;
    exp_mem_addr = 8'd30; mem_allowed = 1'b1;
    bus.req_addr = {8'd0, 8'd30};
    push_sb(2'b01, 8'd30, 8'h00, 0);
    bus.req = 2'b01;
    for (int k = 0; k < 20 && !bus.mem_req; k++) @(negedge clk);
    check_eq("abort_mem_req_seen", bus.mem_req, 1'b1);
    next_drive();
    rst = 1'b1; bus.req = 2'b00;
    sb_q.delete();
    next_drive();
    rst = 1'b0; mem_allowed = 1'b0; late_ack_req = 1'b1;
    exp_hit = 0; exp_miss = 0;
    @(negedge clk);
    check_eq("abort_mem_req_drop", bus.mem_req, 1'b0);
    next_drive();
    late_ack_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_eq("abort_fill_pending", fill_q.size(), 0);
    check_counters("abort");
    $display("ABORT reset-during-miss sequence done cyc=%0d", cyc);

    // saturation: 20 hits on a 4-bit counter
    next_drive();
    hit_mode = 1'b1;
    bus.req_addr = {8'd0, 8'd22};
    for (int i = 0; i < 20; i++) begin
      push_sb(2'b01, 8'd22, 8'hA5, 2);
      exp_hit = sat(exp_hit);
    end
    have_prev = 1'b0; spacing_on = 1'b1;
    bus.req = 2'b01;
    wait_rsp(20, 200);
    next_drive();
    bus.req = 2'b00; spacing_on = 1'b0;
    check_counters("sat");
    check_eq("sat_hit_limit", hit_cnt, 4'd15);
    check_eq("sb_drained", sb_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
